// File: rtl/register_file.sv
// Architectural register file with rename tags: 32 entries of value/busy/dep,
// commit write-back, rename tagging, mispredict flush and same-cycle operand bypass.
module register_file #(
  parameter int ROB_WIDTH_BIT = 5
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     rdy_in,
  input  logic                     clear_flag,
  input  logic [4:0]               commit_reg_id,
  input  logic [31:0]              commit_val,
  input  logic [ROB_WIDTH_BIT-1:0] commit_rob_id,
  input  logic [4:0]               new_reg_id,
  input  logic [ROB_WIDTH_BIT-1:0] new_rob_id,
  input  logic [4:0]               dec_rs1,
  input  logic [4:0]               dec_rs2,
  output logic [31:0]              rs1_val,
  output logic [31:0]              rs2_val,
  output logic                     rs1_has_dep,
  output logic                     rs2_has_dep,
  output logic [ROB_WIDTH_BIT-1:0] rs1_dep,
  output logic [ROB_WIDTH_BIT-1:0] rs2_dep,
  output logic [ROB_WIDTH_BIT-1:0] rob_rs1_id,
  output logic [ROB_WIDTH_BIT-1:0] rob_rs2_id,
  input  logic                     rob_rs1_ready,
  input  logic                     rob_rs2_ready,
  input  logic [31:0]              rob_rs1_val,
  input  logic [31:0]              rob_rs2_val
);

  typedef logic [ROB_WIDTH_BIT-1:0] rob_t;

  logic [31:0] value_q [32];
  logic [31:0] value_d [32];
  logic [31:0] busy_q;
  logic [31:0] busy_d;
  rob_t        dep_q   [32];
  rob_t        dep_d   [32];

  // Next state: commit write, then flush or rename (rename wins over commit clear)
  always_comb begin
    value_d = value_q;
    busy_d  = busy_q;
    dep_d   = dep_q;
    if (rdy_in) begin
      if (commit_reg_id != 5'd0) begin
        value_d[commit_reg_id] = commit_val;
        if (dep_q[commit_reg_id] == commit_rob_id && new_reg_id != commit_reg_id)
          busy_d[commit_reg_id] = 1'b0;
      end
      if (clear_flag) begin
        busy_d = '0;
      end else if (new_reg_id != 5'd0) begin
        busy_d[new_reg_id] = 1'b1;
        dep_d[new_reg_id]  = new_rob_id;
      end
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      for (int i = 0; i < 32; i++) begin
        value_q[i] <= '0;
        dep_q[i]   <= '0;
      end
      busy_q <= '0;
    end else begin
      value_q <= value_d;
      busy_q  <= busy_d;
      dep_q   <= dep_d;
    end
  end

  // Operand lookup on pre-edge state, forwarding the committing value or the ROB reply
  function automatic void read_src(
    input  logic [4:0]  rs,
    input  logic        rob_ready,
    input  logic [31:0] rob_val,
    output logic [31:0] val,
    output logic        has_dep,
    output rob_t        dep,
    output rob_t        rob_id
  );
    val     = '0;
    has_dep = 1'b0;
    dep     = '0;
    rob_id  = '0;
    if (rs != 5'd0) begin
      if (!busy_q[rs]) begin
        val = (commit_reg_id == rs) ? commit_val : value_q[rs];
      end else begin
        rob_id = dep_q[rs];
        if (dep_q[rs] == commit_rob_id) begin
          val = commit_val;
        end else if (rob_ready) begin
          val = rob_val;
        end else begin
          has_dep = 1'b1;
          dep     = dep_q[rs];
        end
      end
    end
  endfunction

  always_comb begin
    read_src(dec_rs1, rob_rs1_ready, rob_rs1_val, rs1_val, rs1_has_dep, rs1_dep, rob_rs1_id);
    read_src(dec_rs2, rob_rs2_ready, rob_rs2_val, rs2_val, rs2_has_dep, rs2_dep, rob_rs2_id);
  end

endmodule

// File: doc/register_file.md
REGISTER_FILE -- requirements
Module: register_file

Interface
REQ-001 SHALL have parameter ROB_WIDTH_BIT, default 5, width of a reorder-buffer entry index (32 entries).
REQ-002 SHALL have port clk_in  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_in  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port rdy_in  input  1  global ready; when low, no state changes.
REQ-005 SHALL have port clear_flag  input  1  branch-mispredict flush from the reorder buffer.
REQ-006 SHALL have port commit_reg_id  input  5  architectural destination of the committing entry; 0 means no write.
REQ-007 SHALL have port commit_val  input  32  committed value.
REQ-008 SHALL have port commit_rob_id  input  ROB_WIDTH_BIT  ROB index of the committing entry.
REQ-009 SHALL have port new_reg_id  input  5  destination register being renamed this cycle; 0 means none.
REQ-010 SHALL have port new_rob_id  input  ROB_WIDTH_BIT  ROB index allocated to the renamed register.
REQ-011 SHALL have ports dec_rs1 and dec_rs2  input  5 each  source register indices from the decoder.
REQ-012 SHALL have ports rs1_val and rs2_val  output  32 each  operand value, valid when the matching has_dep is 0.
REQ-013 SHALL have ports rs1_has_dep and rs2_has_dep  output  1 each  operand still pending.
REQ-014 SHALL have ports rs1_dep and rs2_dep  output  ROB_WIDTH_BIT each  ROB index that will produce the pending operand.
REQ-015 SHALL have ports rob_rs1_id and rob_rs2_id  output  ROB_WIDTH_BIT each  ROB index queried for early readiness.
REQ-016 SHALL have ports rob_rs1_ready and rob_rs2_ready  input  1 each, and rob_rs1_val and rob_rs2_val  input  32 each  ROB reply to the queries.

Function
REQ-017 SHALL hold 32 entries, each with value[31:0], busy and dep[ROB_WIDTH_BIT-1:0].
REQ-018 Entry x0 SHALL always read value 0 with has_dep 0; writes and renames to x0 SHALL be ignored.
REQ-019 Commit (rdy_in high, commit_reg_id != 0) SHALL write commit_val into value[commit_reg_id] on the next edge.
REQ-020 Commit SHALL clear busy[commit_reg_id] only when dep[commit_reg_id] == commit_rob_id and the same register is not renamed in that cycle.
REQ-021 Rename (rdy_in high, clear_flag low, new_reg_id != 0) SHALL set busy=1 and dep=new_rob_id; rename SHALL override a same-cycle commit clear on the same register.
REQ-022 clear_flag with rdy_in high SHALL clear every busy bit on the next edge, ignore that cycle's rename, and still perform that cycle's commit value write.
REQ-023 The read path SHALL be combinational and SHALL reflect pre-edge state, so an instruction's sources never see its own rename.
REQ-024 For source rsN != 0 with busy low: rsN_val=value and has_dep=0; if commit_reg_id==rsN this cycle, rsN_val=commit_val instead.
REQ-025 For source rsN with busy high: rob_rsN_id=dep; if dep==commit_rob_id, or rob_rsN_ready is high, has_dep=0 and val=commit_val or rob_rsN_val respectively; otherwise has_dep=1, rsN_dep=dep, rsN_val=0.
REQ-026 rob_rsN_id SHALL be 0 when the source is not busy; rsN_dep SHALL be 0 whenever has_dep is 0.
REQ-027 With rdy_in low, all array state SHALL hold; combinational outputs remain driven.

Reset
REQ-028 rst_in high SHALL asynchronously set all value, busy and dep to 0, so all reads return 0 with no dependency.
REQ-029 Deassertion of reset mid-stream SHALL need no further initialisation; the first post-reset edge SHALL obey REQ-019..REQ-022.

Verification
REQ-030 Rename x5->ROB 3, then query dec_rs1=5 with rob_rs1_ready=0 -> rs1_has_dep=1, rs1_dep=3, rob_rs1_id=3.
REQ-031 x5 busy on ROB 3; commit reg 5, ROB 3, val 0x1234 -> same-cycle read returns 0x1234 with has_dep=0; next cycle busy[5]=0 and value 0x1234.
REQ-032 x5 renamed to ROB 3, then to ROB 7; commit ROB 3 val 9 -> value[5]=9, busy stays 1, dep=7.
REQ-033 Same cycle: commit reg 6 ROB 2 while renaming reg 6 to ROB 4 -> busy[6]=1, dep=4, value[6]=commit_val.
REQ-034 x1,x2,x3 busy; pulse clear_flag with new_reg_id=4 -> all busy 0, x4 not renamed, values unchanged.
REQ-035 Commit reg 0 val 0xFFFF, then read dec_rs2=0 -> rs2_val=0, rs2_has_dep=0; assert rst_in mid-run -> all outputs 0 immediately.
